// File: rtl/reg_bank_arb_pkg.sv
// Shared types, defaults and helpers for the reg_bank_arb register-bank arbiter.
package reg_bank_arb_pkg;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_MAX_LOCK = 8;
    localparam int MAX_NREQ     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [MAX_NREQ-1:0] to_onehot(input int unsigned idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_bank_arb_rr_pick.sv
// Combinational rotate-priority picker: first set bit of (req & mask), scanning from ptr upward.
module rr_pick
    import reg_bank_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [NREQ-1:0] cand;

    assign cand = req & mask;

    // Scan from the far end so the candidate closest to ptr is written last and wins.
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (cand[j]) begin
                idx = PW'(j);
                any = 1'b1;
            end
        end
    end

    assign onehot = any ? NREQ'(to_onehot(32'(idx))) : '0;

endmodule

// File: rtl/reg_bank_arb.sv
// Round-robin arbiter owning a small register bank; optional lock timeout via REG_BANK_ARB_LOCK_TIMEOUT_EN.
module reg_bank_arb
    import reg_bank_arb_pkg::*;
#(
    parameter  int NREQ     = DEF_NREQ,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int MAX_LOCK = DEF_MAX_LOCK,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ-1:0]       we,
    input  logic [NREQ*AW-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  lock_to
);

    localparam int PW = $clog2(NREQ);

    state_t                      state;
    logic [PW-1:0]               ptr, widx, nptr, pick_ptr, pick_idx;
    logic [NREQ-1:0]             pick_mask, pick_oh;
    logic                        pick_any;
    logic                        active, go, hold_on, timeout;
    logic [AW-1:0]               acc_addr;
    logic [WIDTH-1:0]            acc_wdata;
    logic [DEPTH-1:0][WIDTH-1:0] bank;

    assign active    = (state != IDLE);
    assign nptr      = (widx == PW'(NREQ - 1)) ? '0 : widx + PW'(1);
    assign go        = active && req[widx];
    assign hold_on   = active && lock[widx] && !timeout;
    assign acc_addr  = addr[int'(widx)*AW +: AW];
    assign acc_wdata = wdata[int'(widx)*WIDTH +: WIDTH];

    // One picker serves both paths: fresh pick from IDLE, or hand-off excluding the current owner.
    assign pick_ptr  = active ? nptr : ptr;
    assign pick_mask = active ? ~gnt : '1;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef REG_BANK_ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0] cnt;

    // cnt is the number of completed cycles the current grant has been held.
    always_ff @(posedge clk) begin
        if (rst || !hold_on) cnt <= '0;
        else                 cnt <= cnt + CW'(1);
    end

    assign timeout = active && (cnt == CW'(MAX_LOCK - 1));
`else
    // Constant false; locks never expire in this build.
    assign timeout = (MAX_LOCK < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            widx    <= '0;
            gnt     <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            lock_to <= 1'b0;
            bank    <= '0;
        end else begin
            rvalid  <= 1'b0;
            lock_to <= 1'b0;
            if (go) begin
                if (we[widx]) bank[acc_addr] <= acc_wdata;
                else begin
                    rdata  <= bank[acc_addr];
                    rvalid <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt   <= pick_oh;
                        widx  <= pick_idx;
                        state <= GRANT;
                    end
                end
                GRANT, HOLD: begin
                    ptr <= nptr;
                    if (hold_on) begin
                        state <= HOLD;
                    end else begin
                        lock_to <= lock[widx] && timeout;
                        if (pick_any) begin
                            gnt   <= pick_oh;
                            widx  <= pick_idx;
                            state <= GRANT;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
